// File: rtl/sjf_arbiter.sv
// Shortest-job-first arbiter: grants one of four requesters to a shared unit for
// len+1 cycles, with per-requester skip counters that force long jobs through.
//   state | meaning
//   IDLE  | no grant; arbitrate on any request
//   RUN   | grant held, duration counter counts down to 0
//   GAP   | single dead cycle after a job ends or aborts
module sjf_arbiter #(
  parameter int LEN_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [LEN_W-1:0] len_a,
  input  logic [LEN_W-1:0] len_b,
  input  logic [LEN_W-1:0] len_c,
  input  logic [LEN_W-1:0] len_d,
  output logic [3:0]       grant,
  output logic [1:0]       grant_pos,
  output logic             busy,
  output logic             done,
  output logic             abort
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       pos_q, pos_d;
  logic             abort_q, abort_d;
  logic [2:0]       skip_q [4];
  logic [2:0]       skip_d [4];

  logic [LEN_W-1:0] lens [4];
  logic [1:0]       win_idx;
  logic             starve_hit;
  logic             found;
  logic [LEN_W-1:0] best_len;

  assign lens[0] = len_a;
  assign lens[1] = len_b;
  assign lens[2] = len_c;
  assign lens[3] = len_d;

  // Starved requesters pre-empt the length comparison; lowest index wins ties.
  always_comb begin
    win_idx    = 2'd0;
    starve_hit = 1'b0;
    found      = 1'b0;
    best_len   = '1;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && (skip_q[i] >= 3'(STARVE_LIMIT)) && !starve_hit) begin
        starve_hit = 1'b1;
        win_idx    = 2'(i);
      end
    end
    if (!starve_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i] && (!found || (lens[i] < best_len))) begin
          found    = 1'b1;
          best_len = lens[i];
          win_idx  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    pos_d   = pos_q;
    abort_d = 1'b0;
    skip_d  = skip_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = RUN;
          grant_d = 4'b0001 << win_idx;
          pos_d   = win_idx;
          cnt_d   = lens[win_idx];
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == win_idx) begin
              skip_d[i] = 3'd0;
            end else if (req[i] && (skip_q[i] != 3'd7)) begin
              skip_d[i] = skip_q[i] + 3'd1;
            end
          end
        end
      end
      RUN: begin
        // Completion takes precedence over a request dropped on the same edge.
        if (cnt_q == '0) begin
          state_d = GAP;
          grant_d = 4'b0000;
        end else if (!req[pos_q]) begin
          state_d = GAP;
          grant_d = 4'b0000;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      if (!req[i]) skip_d[i] = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
      pos_q   <= 2'd0;
      abort_q <= 1'b0;
      for (int i = 0; i < 4; i++) skip_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      pos_q   <= pos_d;
      abort_q <= abort_d;
      skip_q  <= skip_d;
    end
  end

  assign grant     = grant_q;
  assign grant_pos = pos_q;
  assign busy      = |grant_q;
  assign done      = (state_q == RUN) && (cnt_q == '0);
  assign abort     = abort_q;

endmodule

// File: tb/tb_sjf_arbiter.sv
// Scoreboard bench for sjf_arbiter: the driver queues the grant it expects for each
// job; a negedge monitor pops one entry per grant and checks duration and end pulse.
module tb_sjf_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [2:0] len_a, len_b, len_c, len_d;
  logic [3:0] grant;
  logic [1:0] grant_pos;
  logic       busy, done, abort;

  sjf_arbiter #(.LEN_W(3), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .len_a(len_a), .len_b(len_b), .len_c(len_c), .len_d(len_d),
    .grant(grant), .grant_pos(grant_pos), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  // kind: 0 = ends with done, 1 = ends with abort, 2 = cut by reset (no end check)
  typedef struct {
    logic [3:0] g;
    logic [1:0] p;
    int         dur;
    int         kind;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] p, input int dur, input int kind);
    exp_t e;
    e.g = g; e.p = p; e.dur = dur; e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_end(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || abort) && n < lim);
    if (!(done || abort)) begin
      total++; bad++;
      $display("FAIL wait_end timeout after %0d cycles", n);
    end
  endtask

  task automatic wait_grant(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 4'b0000 && n < lim);
    if (grant == 4'b0000) begin
      total++; bad++;
      $display("FAIL wait_grant timeout after %0d cycles", n);
    end
  endtask

  exp_t cur;
  logic active = 1'b0;
  int   ncyc, ndone, done_at;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
    end else begin
      check("busy_vs_grant", {31'd0, busy}, {31'd0, |grant});
      check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
      check("done_and_abort", {31'd0, done & abort}, 32'd0);
      if (grant != 4'b0000 && !active) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: got %0h expected none", grant);
        end else begin
          cur = exp_q.pop_front();
          check("grant_value", {28'd0, grant}, {28'd0, cur.g});
          check("grant_pos", {30'd0, grant_pos}, {30'd0, cur.p});
          active  = 1'b1;
          ncyc    = 0;
          ndone   = 0;
          done_at = 0;
        end
      end
      if (active && grant != 4'b0000) begin
        ncyc++;
        if (grant != cur.g) check("grant_hold", {28'd0, grant}, {28'd0, cur.g});
        if (done) begin
          ndone++;
          done_at = ncyc;
        end
      end else if (active && grant == 4'b0000) begin
        active = 1'b0;
        if (cur.kind != 2) check("grant_duration", ncyc, cur.dur);
        if (cur.kind == 0) begin
          check("done_count", ndone, 1);
          check("done_last_cycle", done_at, cur.dur);
          check("no_abort_on_done", {31'd0, abort}, 32'd0);
        end else if (cur.kind == 1) begin
          check("no_done_on_abort", ndone, 0);
          check("abort_pulse", {31'd0, abort}, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'b0000;
    len_a = 3'd0; len_b = 3'd0; len_c = 3'd0; len_d = 3'd0;
    #1;
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_pos", {30'd0, grant_pos}, 32'd0);
    check("rst_busy_done_abort", {29'd0, busy, done, abort}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Min select: b (len 2) then d (len 3) once b drops.
    req = 4'b1111; len_a = 3'd5; len_b = 3'd2; len_c = 3'd6; len_d = 3'd3;
    push(4'b0010, 2'd1, 3, 0);
    push(4'b1000, 2'd3, 4, 0);
    wait_end(20);
    req = 4'b1101;
    wait_end(20);
    req = 4'b0000;
    tick(3);

    // Tie at len 0: c first for one cycle, then d.
    req = 4'b1100; len_a = 3'd1; len_b = 3'd1; len_c = 3'd0; len_d = 3'd0;
    push(4'b0100, 2'd2, 1, 0);
    push(4'b1000, 2'd3, 1, 0);
    wait_end(20);
    req = 4'b1000;
    wait_end(20);
    req = 4'b0000;
    tick(3);

    // Starvation: b wins four times, then a is forced through for 8 cycles.
    req = 4'b0011; len_a = 3'd7; len_b = 3'd1; len_c = 3'd0; len_d = 3'd0;
    for (int i = 0; i < 4; i++) push(4'b0010, 2'd1, 2, 0);
    push(4'b0001, 2'd0, 8, 0);
    for (int i = 0; i < 5; i++) wait_end(30);
    req = 4'b0000;
    tick(3);

    // Abort: a drops req in its second RUN cycle, then pending c runs.
    req = 4'b0101; len_a = 3'd6; len_c = 3'd7;
    push(4'b0001, 2'd0, 2, 1);
    push(4'b0100, 2'd2, 8, 0);
    wait_grant(10);
    tick(1);
    req = 4'b0100;
    wait_end(10);
    wait_end(20);
    req = 4'b0000;
    tick(2);

    // Idle: no request means no grant, grant_pos stays on c, no pulses.
    for (int i = 0; i < 8; i++) begin
      len_a = 3'($urandom_range(0, 7)); len_b = 3'($urandom_range(0, 7));
      len_c = 3'($urandom_range(0, 7)); len_d = 3'($urandom_range(0, 7));
      tick(1);
      check("idle_grant", {28'd0, grant}, 32'd0);
      check("idle_pos", {30'd0, grant_pos}, 32'd2);
      check("idle_pulses", {30'd0, done, abort}, 32'd0);
    end

    // Reset mid-job during c's RUN.
    req = 4'b0100; len_c = 3'd5;
    push(4'b0100, 2'd2, 0, 2);
    wait_grant(10);
    tick(2);
    rst = 1'b1;
    #1;
    check("midrst_grant", {28'd0, grant}, 32'd0);
    check("midrst_busy_done_abort", {29'd0, busy, done, abort}, 32'd0);
    check("midrst_pos", {30'd0, grant_pos}, 32'd0);
    @(negedge clk);
    push(4'b0001, 2'd0, 3, 0);
    rst = 1'b0; req = 4'b0001; len_a = 3'd2;
    @(posedge clk);
    #1;
    check("post_rst_grant", {28'd0, grant}, 32'd1);
    wait_end(20);
    req = 4'b0000;
    tick(5);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sjf_arbiter.md
Name: sjf_arbiter

Overview:
- Shortest-job-first arbiter that shares one execution resource among four requesters (a, b, c, d).
- Each requester presents a request and a 3-bit job length. The block grants the resource to the active requester with the smallest length and holds the grant for the job duration.
- An anti-starvation skip counter per requester stops long jobs from waiting forever.
- Sits in front of the shared datapath unit. It generalises the registered minimum-position selection into a full sequenced grant controller.

Parameters:
- LEN_W, 3, width of each job-length input and of the duration counter.
- STARVE_LIMIT, 4, number of lost arbitrations after which a waiting requester is forced to win (range 1..7).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- req  input  4  request lines; bit0=a, bit1=b, bit2=c, bit3=d.
- len_a  input  LEN_W  job length of requester a; len_b, len_c, len_d are identical for b, c, d.
- grant  output  4  one-hot grant, same bit order as req.
- grant_pos  output  2  encoded index of the current or last winner.
- busy  output  1  high while any grant is asserted.
- done  output  1  one-cycle pulse during the final cycle of a completed job.
- abort  output  1  one-cycle pulse when the granted requester drops req mid-job.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - grant=0, grant_pos=0, busy=0, done=0, abort=0.
  - Duration counter=0, all skip counters=0, state=IDLE.
- States:
  - IDLE: grant=0.
  - RUN: grant holds one-hot winner, counter decrements.
  - GAP: one cycle with grant=0, then return to IDLE.
- IDLE -> RUN, at a posedge with req!=0:
  - Winner is chosen from the values sampled at that edge.
  - grant, grant_pos and busy update at that same edge, so grant appears 1 cycle after req is sampled.
  - Counter loads the winner's len.
- Winner selection, in priority order:
  - (1) Any requesting requester whose skip counter is >= STARVE_LIMIT wins; among several, the lowest index wins.
  - (2) Otherwise the requesting requester with the minimum len wins, compared unsigned; ties go to the lowest index.
  - A non-requesting requester never wins, whatever its len.
- Skip counters, updated at the arbitration edge only:
  - Winner's counter is cleared.
  - Each other requester with req=1 increments, saturating at 7.
  - Any requester with req=0 in any cycle has its counter cleared.
- RUN duration:
  - Grant is held for len+1 cycles, so len=0 gives 1 cycle and len=7 gives 8 cycles.
  - Counter decrements each posedge while in RUN.
  - done=1 in the cycle where counter==0 (combinational on state/counter, or registered equivalently so it is visible in that same cycle).
  - At the following posedge: grant=0, busy=0, state=GAP.
- Abort:
  - If the granted requester's req is sampled 0 at a posedge in RUN before completion: grant=0, busy=0, state=GAP.
  - abort=1 for the one cycle after that edge; done is not pulsed.
  - If req drops at the same edge the job completes (counter==0), it is treated as a normal completion, not an abort.
- GAP: exactly one cycle with grant=0, then IDLE. The earliest next grant is therefore 2 cycles after the previous grant falls.
- Inputs during RUN:
  - len inputs are ignored while in RUN; the length is latched at the grant.
  - New requests arriving during RUN wait; no preemption.
- grant_pos holds the last winner's index while idle.
- Invariants:
  - grant is always 0 or one-hot.
  - busy == |grant.
  - done and abort are never both 1.
- Reset asserted mid-RUN: grant drops at once, with no done or abort pulse.

Test Plan:
- Min select: req=1111, len a..d = 5,2,6,3 -> grant=0010, grant_pos=1, busy for 3 cycles, done in the 3rd cycle, then 1 GAP cycle, then grant=1000 (d, len 3).
- Ties and len=0: req=1100, len_c=0, len_d=0 -> grant=0100 for exactly 1 cycle with done in that cycle; next grant goes to d.
- Starvation: req_a held with len_a=7 while b re-requests with len_b=1 after every grant -> b wins 4 times, then a wins on the 5th arbitration (skip_a=4) and its grant lasts 8 cycles.
- Abort: a granted with len_a=6, req_a drops 2 cycles into RUN -> grant=0 at the next edge, abort one-cycle pulse, no done, GAP, then the pending requester is granted.
- Reset mid-job: rst pulsed during c's RUN -> grant, busy, done and abort are 0 immediately; after release with req=0001, a is granted 1 cycle later.
- Idle ignore: req=0000 with arbitrary len values -> grant stays 0, grant_pos is unchanged, and no done or abort pulses occur.
